// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows a 32-bit register value into a byte, halfword or
// word store on a word-organised data memory with a one-cycle read latency.
// Sub-word stores run a read-modify-write (IDLE -> RD -> WR -> DONE); word
// stores skip the read; misaligned or illegal requests go straight to DONE
// with err_o set and never touch memory.
// Optional feature: define NARROW_OVF_CHK_EN to build the ovf_o check that
// flags sub-word data which does not survive narrowing as a signed value.
module store_narrow_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic [1:0]        size_i,
  output logic              done_o,
  output logic              err_o,
  output logic              ovf_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic              mem_re_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [1:0]        size_q;
  logic              err_q;
  logic              accept;
  logic              bad_req;
  logic [31:0]       merged;

  assign accept = req_i && (state == IDLE);

  // Reject illegal sizes and stores that are not naturally aligned
  always_comb begin
    bad_req = 1'b0;
    case (size_i)
      SIZE_HALF: bad_req = addr_i[0];
      SIZE_WORD: bad_req = (addr_i[1:0] != 2'b00);
      2'b11:     bad_req = 1'b1;
      default:   bad_req = 1'b0;
    endcase
  end

  // State register plus request fields captured at accept
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q <= addr_i;
        data_q <= data_i;
        size_q <= size_i;
        err_q  <= bad_req;
      end
    end
  end

  // Splice the narrowed store data into the word read back from memory
  always_comb begin
    merged = mem_rdata_i;
    case (size_q)
      SIZE_BYTE: merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
      SIZE_HALF: begin
        if (addr_q[1]) begin
          merged[31:16] = data_q[15:0];
        end else begin
          merged[15:0] = data_q[15:0];
        end
      end
      default: merged = data_q;
    endcase
  end

  // Next-state selection and output decode from the state register
  always_comb begin
    state_next  = state;
    ready_o     = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (req_i) begin
          if (bad_req) begin
            state_next = DONE;
          end else if (size_i == SIZE_WORD) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: begin
        mem_re_o   = 1'b1;
        mem_addr_o = addr_q[ADDR_W-1:2];
        state_next = WR;
      end
      WR: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_q[ADDR_W-1:2];
        mem_wdata_o = merged;
        state_next  = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        err_o      = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef NARROW_OVF_CHK_EN
  logic ovf_flag;

  // Detect store data whose upper bits are not a sign extension of the kept part
  always_comb begin
    ovf_flag = 1'b0;
    case (size_q)
      SIZE_BYTE: ovf_flag = (data_q[31:8] != {24{data_q[7]}});
      SIZE_HALF: ovf_flag = (data_q[31:16] != {16{data_q[15]}});
      default:   ovf_flag = 1'b0;
    endcase
  end

  assign ovf_o = (state == DONE) && !err_q && ovf_flag;
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Store-side counterpart of the load-path sign extension. It narrows a 32-bit register value to a byte, halfword or word store into the word-organised data memory.
- Sub-word stores use a read-modify-write sequence over a one-cycle-latency memory port. Word stores write directly.
- Sits between the MEM-stage store request and data memory.
- Handshake: req/ready in, done/err out.

Parameters:
- ADDR_W, 32, byte-address width; memory word address is addr_i[ADDR_W-1:2].

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  1  store request; accepted when req_i && ready_o.
- ready_o  out  1  high only in IDLE.
- addr_i  in  ADDR_W  byte address; sampled at accept.
- data_i  in  32  store data; the value sits in the low bits; sampled at accept.
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal; sampled at accept.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid with done_o; 1 = request rejected, no memory access made.
- ovf_o  out  1  valid with done_o; see Optional Feature.
- mem_addr_o  out  ADDR_W-2  word address.
- mem_re_o  out  1  read strobe.
- mem_rdata_i  in  32  read data; valid in the cycle after mem_re_o.
- mem_we_o  out  1  write strobe.
- mem_wdata_o  out  32  write data.

Behaviour:
- Clocking/reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Output decode:
  - All outputs are decoded from the state register and latched request fields.
  - After a reset edge: state IDLE, ready_o=1. done_o, err_o, ovf_o, mem_re_o and mem_we_o are 0. mem_addr_o and mem_wdata_o are 0.
- States: IDLE, RD, WR, DONE.
- IDLE: ready_o=1. On req_i, latch addr/data/size, then transition:
  - illegal size_i (11) -> DONE with err.
  - half with addr[0]=1 -> DONE with err.
  - word with addr[1:0]!=0 -> DONE with err.
  - word -> WR.
  - byte/half -> RD.
- RD: mem_re_o=1 and mem_addr_o=word address. Next state WR.
- WR: mem_we_o=1, same mem_addr_o. mem_wdata_o is:
  - word: latched data.
  - byte: mem_rdata_i with lane addr[1:0] replaced by data[7:0]. Little-endian; lane n = bits 8n+7:8n.
  - half: mem_rdata_i with bits [31:16] (addr[1]=1) or [15:0] (addr[1]=0) replaced by data[15:0].
  - Next state DONE.
- DONE: done_o=1 and err_o/ovf_o valid; ready_o=0. Next state IDLE.
- Latency (counting the accept cycle as 0):
  - sub-word: done_o in cycle 3.
  - word: done_o in cycle 2.
  - error: done_o in cycle 1.
  - Next accept is possible the cycle after DONE.
- req_i outside IDLE is ignored; no queuing.
- Request inputs are ignored after accept; changes mid-operation have no effect.
- Reset mid-operation:
  - The cycle with rst_i high still shows the current-state strobes.
  - The following cycle is IDLE.
  - A reset during RD means no write is ever issued.
- At most one mem_re_o and one mem_we_o per request. An erroneous request issues neither.

Optional Feature:
- Macro: NARROW_OVF_CHK_EN.
- Defined:
  - For byte stores, ovf_o=1 when data[31:8] is not all equal to data[7].
  - For half stores, ovf_o=1 when data[31:16] is not all equal to data[15].
  - Word stores and error cases give ovf_o=0.
  - ovf_o is informational only: the store is still performed.
- Not defined: ovf_o is tied to 0 and no check logic is built.

Test Plan:
- Preload word 0x10 with 0xAABBCCDD. Byte store at addr 0x11, data 0x00000055:
  - mem_re_o in cycle 1, addr 0x4.
  - mem_we_o in cycle 2, wdata 0xAABB55DD.
  - done_o in cycle 3, err_o=0.
- Half store at 0x12:
  - data 0xFFFF8001 -> wdata 0x8001CCDD, ovf_o=0.
  - data 0x00008001 -> same write. ovf_o=1 with NARROW_OVF_CHK_EN, 0 without.
- Word store at 0x10, data 0x12345678:
  - no mem_re_o.
  - mem_we_o in cycle 1, wdata 0x12345678.
  - done_o in cycle 2.
- Error requests, each giving done_o=1 and err_o=1 in cycle 1 with no mem_re_o or mem_we_o:
  - half at 0x13.
  - word at 0x12.
  - size_i=11 at 0x10.
- Assert rst_i during RD of a byte store:
  - next cycle ready_o=1, all strobes 0.
  - mem_we_o never asserted.
  - memory still 0xAABBCCDD.
- Hold req_i high continuously with changing data:
  - only one request is accepted per IDLE visit.
  - requests are spaced 4 cycles apart for sub-word stores.
  - each write uses the data latched at its own accept.
